clk_div_cfg: RTL and testbench

- Programmable integer clock divider, successor to the fixed-ratio divider.
- Adds a runtime ratio-update handshake, glitch-free ratio changes at period boundaries, and clean start/stop gating on period boundaries.
- Adds a rising-edge tick output, illegal-ratio flagging, and exact duty-cycle rules for odd ratios.
- Sits in the clock/reset subsystem; drives peripheral baud/sample clocks from i_clk_ref.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_ratio_reg.sv | 64 ++++++
 rtl/clk_div_cfg.sv | 108 ++++++++++
 tb/tb_clk_div_cfg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the configurable clock divider.
// Half-ratio helpers work on 32 bits so any legal WIDTH fits without overflow.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

    localparam int unsigned MIN_RATIO = 2;

    function automatic logic [31:0] half_ceil(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

    function automatic logic [31:0] half_floor(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ratio_reg.sv
// Ratio load validation, pending ratio, sticky error and adoption of the
// pending ratio on the period-start strobe from the divider FSM.
module clk_div_ratio_reg
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] ratio_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] active_ratio_o,
    output logic             err_o
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             legal;

    assign legal = ratio_i >= WIDTH'(MIN_RATIO);

    always_comb begin
        pend_d   = pend_q;
        active_d = active_q;
        vld_d    = vld_q;
        err_d    = err_q;
        if (start_i && vld_q) begin
            active_d = pend_q;
            vld_d    = 1'b0;
        end
        // A load in the start cycle lands after adoption, so it waits for the next period.
        if (load_i) begin
            if (legal) begin
                pend_d = ratio_i;
                vld_d  = 1'b1;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q   <= WIDTH'(DEFAULT_RATIO);
            active_q <= WIDTH'(DEFAULT_RATIO);
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            active_q <= active_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign active_ratio_o = active_q;
    assign err_o          = err_q;

endmodule

// File: rtl/clk_div_cfg.sv
// Programmable integer clock divider: HIGH for ceil(N/2), LOW for floor(N/2) ref cycles,
// with start/stop and ratio changes only at period boundaries.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic             i_clk_ref,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_div_ratio,
    input  logic             i_ratio_load,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_active_ratio,
    output logic             o_ratio_err,
    output logic             o_running
);

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             div_q;
    logic             tick_q;
    logic [WIDTH-1:0] h_len;
    logic [WIDTH-1:0] l_len;
    logic             period_start;

    assign h_len = WIDTH'(half_ceil(32'(o_active_ratio)));
    assign l_len = WIDTH'(half_floor(32'(o_active_ratio)));

    always_comb begin
        period_start = 1'b0;
        unique case (state_q)
            StIdle:  period_start = i_clk_en;
            StLow:   period_start = i_clk_en && (cnt_q == l_len);
            default: period_start = 1'b0;
        endcase
    end

    clk_div_ratio_reg #(
        .WIDTH         (WIDTH),
        .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_ratio_reg (
        .clk_i          (i_clk_ref),
        .rst_ni         (i_rst_n),
        .load_i         (i_ratio_load),
        .ratio_i        (i_div_ratio),
        .start_i        (period_start),
        .active_ratio_o (o_active_ratio),
        .err_o          (o_ratio_err)
    );

    always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= WIDTH'(1);
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    div_q <= 1'b0;
                    if (i_clk_en) begin
                        state_q <= StHigh;
                        cnt_q   <= WIDTH'(1);
                        div_q   <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                StHigh: begin
                    if (cnt_q == h_len) begin
                        state_q <= StLow;
                        cnt_q   <= WIDTH'(1);
                        div_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                StLow: begin
                    if (cnt_q == l_len) begin
                        cnt_q <= WIDTH'(1);
                        if (i_clk_en) begin
                            state_q <= StHigh;
                            div_q   <= 1'b1;
                            tick_q  <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= WIDTH'(1);
                    div_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_div_clk = div_q;
    assign o_tick    = tick_q;
    assign o_running = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_cfg.sv
// Scoreboard bench for clk_div_cfg: a period-position reference model pushes the expected
// outputs per cycle, a monitor pops and compares them one ref cycle later.
module tb_clk_div_cfg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEF   = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] ratio_in;
    logic             load;
    logic             div_clk;
    logic             tick;
    logic [WIDTH-1:0] active_ratio;
    logic             ratio_err;
    logic             running;

    clk_div_cfg #(
        .WIDTH         (WIDTH),
        .DEFAULT_RATIO (DEF)
    ) dut (
        .i_clk_ref      (clk),
        .i_rst_n        (rst_n),
        .i_clk_en       (en),
        .i_div_ratio    (ratio_in),
        .i_ratio_load   (load),
        .o_div_clk      (div_clk),
        .o_tick         (tick),
        .o_active_ratio (active_ratio),
        .o_ratio_err    (ratio_err),
        .o_running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [WIDTH+3:0] exp_q[$];

    // Reference model: is a period in progress, which cycle of it we are in, and ratio state.
    bit          m_run;
    int unsigned m_pos;
    int unsigned m_ratio;
    int unsigned m_pend;
    bit          m_pvld;
    bit          m_err;

    function automatic logic [WIDTH+3:0] model_out();
        int unsigned h;
        bit d;
        bit t;
        h = (m_ratio + 1) / 2;
        d = m_run && (m_pos < h);
        t = m_run && (m_pos == 0);
        return {d, t, m_run, m_err, m_ratio[WIDTH-1:0]};
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_pos   = 0;
        m_ratio = DEF;
        m_pend  = 0;
        m_pvld  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit ld, input int unsigned r);
        bit boundary;
        bit start;
        boundary = !m_run || (m_pos == m_ratio - 1);
        start    = boundary && e;
        if (start && m_pvld) begin
            m_ratio = m_pend;
            m_pvld  = 1'b0;
        end
        if (ld) begin
            if (r >= 2) begin
                m_pend = r;
                m_pvld = 1'b1;
                m_err  = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (start) begin
            m_run = 1'b1;
            m_pos = 0;
        end else if (boundary) begin
            m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic drive(input bit e, input bit ld, input int unsigned r);
        en       = e;
        load     = ld;
        ratio_in = WIDTH'(r);
        model_step(e, ld, r);
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input bit e, input bit ld, input int unsigned r);
        @(negedge clk);
        drive(e, ld, r);
    endtask

    task automatic run(input int unsigned n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
    endtask

    task automatic check_reset_state(input string name);
        logic [WIDTH+3:0] act;
        logic [WIDTH+3:0] req;
        act = {div_clk, tick, running, ratio_err, active_ratio};
        req = {1'b0, 1'b0, 1'b0, 1'b0, WIDTH'(DEF)};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Assert reset between edges, check outputs immediately, release at a falling edge.
    task automatic apply_reset(input string name);
        en    = 1'b0;
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state(name);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 0);
    endtask

    // Monitor: the DUT presents a result every ref cycle; compare it with the oldest expectation.
    initial begin
        logic [WIDTH+3:0] e;
        logic [WIDTH+3:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {div_clk, tick, running, ratio_err, active_ratio};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got div=%b tick=%b run=%b err=%b ratio=%0d required div=%b tick=%b run=%b err=%b ratio=%0d",
                             $time, a[WIDTH+3], a[WIDTH+2], a[WIDTH+1], a[WIDTH], a[WIDTH-1:0],
                             e[WIDTH+3], e[WIDTH+2], e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        int unsigned guard;
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        ratio_in = '0;
        model_reset();
        #12;
        apply_reset("reset_initial");

        // Default ratio 2.
        run(10);
        // Ratio 5.
        cyc(1'b1, 1'b1, 5);
        run(20);
        // Ratio 4, then 7 loaded while running.
        cyc(1'b1, 1'b1, 4);
        run(12);
        cyc(1'b1, 1'b1, 7);
        run(20);
        // Illegal loads, then a legal one.
        cyc(1'b1, 1'b1, 1);
        cyc(1'b1, 1'b1, 0);
        run(6);
        cyc(1'b1, 1'b1, 3);
        run(10);
        // Ratio 6 with stop and restart.
        cyc(1'b1, 1'b1, 6);
        run(14);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0);
        run(16);
        for (int i = 0; i < 40; i++) cyc(($urandom_range(0, 3) != 0), 1'b0, 0);
        // Maximum ratio.
        cyc(1'b1, 1'b1, 255);
        run(600);
        // Reset in the middle of a HIGH phase.
        guard = 0;
        while (!(m_run && m_pos > 0 && m_pos < 100) && guard < 600) begin
            cyc(1'b1, 1'b0, 0);
            guard++;
        end
        @(posedge clk);
        #3;
        apply_reset("reset_mid_high");
        run(10);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            bit          e;
            bit          ld;
            int unsigned r;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 14) == 0);
            r  = $urandom_range(0, 12);
            cyc(e, ld, r);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
